// File: rtl/bit_serial_adder.sv
// bit_serial_adder: LSB-first serial adder built from one full-adder slice and a carry flip-flop
module bit_serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum_out,
    output logic             cout
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] psum;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             s;
    logic             co;

    // one-bit full-adder slice fed by the operand LSBs and the stored carry
    always_comb begin
        s  = a_reg[0] ^ b_reg[0] ^ carry;
        co = (a_reg[0] & b_reg[0]) | (carry & (a_reg[0] ^ b_reg[0]));
    end

    // control FSM with the shifting datapath and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            a_reg   <= '0;
            b_reg   <= '0;
            psum    <= '0;
            carry   <= 1'b0;
            cnt     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            sum_out <= '0;
            cout    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_reg <= a_in;
                        b_reg <= b_in;
                        carry <= cin;
                        cnt   <= '0;
                        psum  <= '0;
                        busy  <= 1'b1;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    carry <= co;
                    psum  <= {s, psum[WIDTH-1:1]};
                    a_reg <= {1'b0, a_reg[WIDTH-1:1]};
                    b_reg <= {1'b0, b_reg[WIDTH-1:1]};
                    cnt   <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1)) begin
                        sum_out <= {s, psum[WIDTH-1:1]};
                        cout    <= co;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bit_serial_adder.sv
// tb_bit_serial_adder: scoreboard bench for the serial adder at WIDTH=8 and WIDTH=2
module tb_bit_serial_adder;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start8 = 1'b0, c8 = 1'b0, busy8, done8, cout8;
    logic [7:0] a8 = '0, b8 = '0, sum8;
    logic       start2 = 1'b0, c2 = 1'b0, busy2, done2, cout2;
    logic [1:0] a2 = '0, b2 = '0, sum2;

    int checks = 0;
    int errors = 0;
    int q8[$];
    int q2[$];

    bit_serial_adder #(.WIDTH(8)) d8 (
        .clk(clk), .rst(rst), .start(start8), .a_in(a8), .b_in(b8), .cin(c8),
        .busy(busy8), .done(done8), .sum_out(sum8), .cout(cout8)
    );

    bit_serial_adder #(.WIDTH(2)) d2 (
        .clk(clk), .rst(rst), .start(start2), .a_in(a2), .b_in(b2), .cin(c2),
        .busy(busy2), .done(done2), .sum_out(sum2), .cout(cout2)
    );

    always #5 clk = ~clk;

    function automatic void chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // monitor for the 8-bit adder: every done pulse pops one expected result
    always @(negedge clk) begin
        if (done8) begin
            if (q8.size() == 0) chk("done8_unexpected", 1, 0);
            else chk("result8", int'({cout8, sum8}), q8.pop_front());
        end
    end

    // monitor for the 2-bit adder
    always @(negedge clk) begin
        if (done2) begin
            if (q2.size() == 0) chk("done2_unexpected", 1, 0);
            else chk("result2", int'({cout2, sum2}), q2.pop_front());
        end
    end

    task automatic wait_idle8();
        int n = 0;
        while ((busy8 || done8) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("idle8_timeout", 1, 0);
    endtask

    task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic c);
        wait_idle8();
        a8 = a; b8 = b; c8 = c; start8 = 1'b1;
        q8.push_back(int'(a) + int'(b) + int'(c));
        @(negedge clk);
        start8 = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom); c8 = 1'($urandom);
    endtask

    task automatic wait_done8(input int lat0, input int b0, output int lat, output int bn);
        lat = lat0;
        bn = b0;
        while (!done8 && lat < 40) begin
            @(negedge clk);
            lat++;
            if (busy8) bn++;
        end
        if (lat >= 40) chk("done8_timeout", 1, 0);
    endtask

    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic c, input string name);
        int lat, bn;
        issue8(a, b, c);
        wait_done8(1, busy8 ? 1 : 0, lat, bn);
        chk({name, "_latency"}, lat, 9);
        chk({name, "_busy_cycles"}, bn, 8);
        @(negedge clk);
        chk({name, "_done_pulse"}, int'(done8), 0);
    endtask

    initial begin
        int lat, bn, n, t0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("reset_busy", int'(busy8), 0);
        chk("reset_done", int'(done8), 0);
        chk("reset_sum", int'(sum8), 0);
        chk("reset_cout", int'(cout8), 0);

        op8(8'h5A, 8'h3C, 1'b0, "basic");
        chk("basic_sum_hold", int'({cout8, sum8}), 9'h096);
        op8(8'hFF, 8'h01, 1'b0, "ripple1");
        op8(8'hFF, 8'hFF, 1'b1, "ripple2");

        // start pulses during SHIFT must be ignored
        issue8(8'h10, 8'h20, 1'b0);
        repeat (2) @(negedge clk);
        a8 = 8'hAA; b8 = 8'h55; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0; a8 = 8'h11; b8 = 8'h22;
        wait_done8(4, 4, lat, bn);
        chk("ignored_latency", lat, 9);
        n = 0;
        repeat (12) begin
            @(negedge clk);
            if (done8) n++;
        end
        chk("ignored_extra_done", n, 0);

        // reset in the middle of an operation abandons it
        issue8(8'h7F, 8'h01, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        void'(q8.pop_back());
        chk("abort_busy", int'(busy8), 0);
        chk("abort_done", int'(done8), 0);
        chk("abort_sum", int'(sum8), 0);
        chk("abort_cout", int'(cout8), 0);
        n = 0;
        repeat (12) begin
            @(negedge clk);
            if (done8) n++;
        end
        chk("abort_no_done", n, 0);
        op8(8'h01, 8'h02, 1'b0, "after_abort");

        // reset wins over a simultaneous start
        rst = 1'b1; start8 = 1'b1; a8 = 8'h33; b8 = 8'h44;
        @(negedge clk);
        rst = 1'b0; start8 = 1'b0;
        @(negedge clk);
        chk("rst_start_busy", int'(busy8), 0);

        // back-to-back with start held high
        wait_idle8();
        a8 = 8'h80; b8 = 8'h80; c8 = 1'b0; start8 = 1'b1;
        q8.push_back(32'h100);
        @(negedge clk);
        a8 = 8'h0F; b8 = 8'hF0; c8 = 1'b1;
        q8.push_back(32'h100);
        wait_done8(1, 1, lat, bn);
        chk("b2b_first_latency", lat, 9);
        t0 = lat;
        repeat (5) @(negedge clk);
        lat += 5;
        chk("b2b_hold", int'({cout8, sum8}), 9'h100);
        chk("b2b_busy", int'(busy8), 1);
        wait_done8(lat, 0, lat, bn);
        start8 = 1'b0;
        chk("b2b_spacing", lat - t0, 10);
        @(negedge clk);

        // randomized operations
        for (int i = 0; i < 20; i++)
            op8(8'($urandom), 8'($urandom), 1'($urandom), "random");

        // exhaustive sweep of the 2-bit instance
        for (int i = 0; i < 32; i++) begin
            n = 0;
            while ((busy2 || done2) && n < 20) begin
                @(negedge clk);
                n++;
            end
            if (n >= 20) chk("idle2_timeout", 1, 0);
            a2 = 2'(i); b2 = 2'(i >> 2); c2 = 1'(i >> 4); start2 = 1'b1;
            q2.push_back((i & 3) + ((i >> 2) & 3) + ((i >> 4) & 1));
            @(negedge clk);
            start2 = 1'b0;
        end
        n = 0;
        while ((q2.size() != 0 || q8.size() != 0) && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("q2_drained", q2.size(), 0);
        chk("q8_drained", q8.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/bit_serial_adder.md
Name: bit_serial_adder

Overview:
- Sequential multi-bit adder built around a single one-bit full-adder slice (a, b, c in; sum, carry out) plus a carry flip-flop.
- Adds two WIDTH-bit operands and a carry-in LSB-first, one bit per clock.
- Consumes the full-adder slice's sum/carry every cycle and feeds the carry back as the slice's c input.
- Intended as the serial datapath stage above the existing full-adder cell on the FPGA prototyping board.

Parameters:
WIDTH, 8, operand/result width in bits; legal range 2..32.

Ports:
clk      input   1      rising-edge clock
rst      input   1      synchronous, active-high reset
start    input   1      request to begin an addition; sampled only in IDLE
a_in     input   WIDTH  operand A; captured on accepted start
b_in     input   WIDTH  operand B; captured on accepted start
cin      input   1      carry-in; captured on accepted start
busy     output  1      high while an addition is in progress (SHIFT state)
done     output  1      one-cycle pulse: result valid
sum_out  output  WIDTH  registered sum; updated only on completion
cout     output  1      registered carry-out; updated only on completion

Behaviour:
- Reset: one clock, rst sampled on the rising edge.
  - Outputs: busy=0, done=0, sum_out=0, cout=0.
  - Internal state: FSM=IDLE, shift registers=0, carry register=0, bit counter=0.
  - rst has priority over every other input in every state.
- FSM states: IDLE, SHIFT, DONE.
  - IDLE -> SHIFT on the edge where start=1.
    - On that edge: A reg<=a_in, B reg<=b_in, carry reg<=cin, counter<=0, partial-sum reg<=0.
  - SHIFT: each edge performs one bit step.
    - Slice inputs: a=A[0], b=B[0], c=carry reg.
    - carry reg <= slice carry.
    - Partial-sum reg shifts right, with slice sum entering at bit WIDTH-1.
    - A reg and B reg shift right (zero fill).
    - counter increments.
  - SHIFT -> DONE on the edge processing the bit where counter==WIDTH-1.
    - Same edge: sum_out <= final shifted partial sum; cout <= slice carry.
  - DONE -> IDLE unconditionally after one cycle.
- Outputs per state:
  - busy=1 exactly in SHIFT.
  - done=1 exactly in DONE.
  - sum_out and cout hold their last value in all other cycles, including during the next computation.
- Latency: if start is sampled at edge k, done is high during the cycle after edge k+WIDTH. This is WIDTH+1 edges after acceptance, and the cycle is exactly WIDTH cycles of busy=1 long.
- Throughput: one addition per WIDTH+2 cycles.
  - start held continuously gives back-to-back operations: IDLE(accept), SHIFT×WIDTH, DONE, IDLE(accept) ...
- start in SHIFT or DONE is ignored. It is not queued, and the operands in flight are unaffected.
- a_in, b_in and cin may change freely after the accepting edge.
- Arithmetic: {cout,sum_out} = a_in + b_in + cin (unsigned, WIDTH+1 bits).
  - Overflow is reported only through cout; there is no wrap flag.
- Counter width: ceil(log2(WIDTH)) bits; no wrap occurs because the FSM leaves SHIFT at WIDTH-1.
- Reset mid-operation (rst in SHIFT or DONE): computation is abandoned.
  - Outputs return to reset values on that edge.
  - No done pulse is produced for the aborted operation.
- Simultaneous rst and start: rst wins, and start is not accepted that edge.

Test Plan:
- Reset then basic add, WIDTH=8: a_in=0x5A, b_in=0x3C, cin=0, start pulse.
  - busy=1 for 8 cycles, then done pulse.
  - sum_out=0x96, cout=0.
- Carry ripple through all bits: a_in=0xFF, b_in=0x01, cin=0 -> sum_out=0x00, cout=1. Then a_in=0xFF, b_in=0xFF, cin=1 -> sum_out=0xFF, cout=1.
- Ignored start: start 0x10+0x20. During SHIFT cycle 3, pulse start with a_in=0xAA, b_in=0x55, and change a_in/b_in.
  - Result is sum_out=0x30, cout=0.
  - Exactly one done pulse, 9 cycles after acceptance.
- Reset mid-operation: start 0x7F+0x01, assert rst in SHIFT cycle 4.
  - Next cycle: busy=0, done=0, sum_out=0, cout=0.
  - No done pulse in the following 12 cycles.
  - A subsequent start 0x01+0x02 yields 0x03.
- Back-to-back with start held high: sequence 0x80+0x80+0 then 0x0F+0xF0+1.
  - done pulses exactly 10 cycles apart.
  - Results are (0x00, cout=1) then (0x00, cout=1).
  - sum_out holds the first result until the second done.
- Exhaustive check with WIDTH=2: all 32 combinations of a_in, b_in, cin.
  - {cout,sum_out} equals a_in+b_in+cin every time.
